// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: reset constants, instruction-memory
// address width and the next-PC select encoding.
package mips_pkg;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam int          IM_AW     = 10;

   typedef enum logic [1:0] {
      SEL_SEQ = 2'd0,
      SEL_BR  = 2'd1,
      SEL_J   = 2'd2,
      SEL_JR  = 2'd3
   } pc_sel_e;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: redirect priority (jr > jump > branch > pc+4),
// jump target concatenation, word-alignment forcing and misalignment detection.
module pc_next_mux
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] if_pc4,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic [31:0] next_pc,
   output logic        redirect,
   output logic        misalign
);

   pc_sel_e     sel;
   logic [31:0] raw_pc;

   always_comb begin
      sel    = SEL_SEQ;
      raw_pc = pc + 32'd4;
      if (jr) begin
         sel    = SEL_JR;
         raw_pc = jr_target;
      end else if (jump) begin
         sel    = SEL_J;
         raw_pc = {if_pc4[31:28], jump_index, 2'b00};
      end else if (br_taken) begin
         sel    = SEL_BR;
         raw_pc = br_target;
      end
      redirect = (sel != SEL_SEQ);
      misalign = redirect && (raw_pc[1:0] != 2'b00);
      // Fetch always continues from the word-aligned address.
      next_pc  = {raw_pc[31:2], 2'b00};
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, instruction-memory addressing, IF/ID pipeline
// register, sticky misalignment flag and saturating fetch/stall counters.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
   parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR,
   parameter int          CNT_W     = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      stall,
   input  logic                      flush,
   input  logic                      br_taken,
   input  logic [31:0]               br_target,
   input  logic                      jump,
   input  logic [25:0]               jump_index,
   input  logic                      jr,
   input  logic [31:0]               jr_target,
   output logic                      im_rd,
   output logic [mips_pkg::IM_AW-1:0] im_addr,
   input  logic [31:0]               im_dout,
   output logic [31:0]               pc,
   output logic [31:0]               if_pc,
   output logic [31:0]               if_pc4,
   output logic [31:0]               if_instr,
   output logic                      if_valid,
   output logic                      pc_misalign,
   output logic [CNT_W-1:0]          fetch_cnt,
   output logic [CNT_W-1:0]          stall_cnt
);

   logic [31:0] next_pc;
   logic [31:0] pc_plus4;
   logic        redirect;
   logic        misalign;

   pc_next_mux u_next (
      .pc         (pc),
      .if_pc4     (if_pc4),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .jump       (jump),
      .jump_index (jump_index),
      .jr         (jr),
      .jr_target  (jr_target),
      .next_pc    (next_pc),
      .redirect   (redirect),
      .misalign   (misalign)
   );

   assign pc_plus4 = pc + 32'd4;
   // Only the 4 KiB window is decoded; upper PC bits alias.
   assign im_addr  = pc[mips_pkg::IM_AW+1:2];
   // Read is enabled from the first cycle after release so RESET_PC is fetched at once.
   assign im_rd    = rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         if_pc       <= '0;
         if_pc4      <= '0;
         if_instr    <= NOP_INSTR;
         if_valid    <= 1'b0;
         pc_misalign <= 1'b0;
         fetch_cnt   <= '0;
         stall_cnt   <= '0;
      end else begin
         if (misalign)
            pc_misalign <= 1'b1;
         if (flush || redirect) begin
            pc       <= next_pc;
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
         end else if (stall) begin
            if (stall_cnt != '1)
               stall_cnt <= stall_cnt + CNT_W'(1);
         end else begin
            pc       <= pc_plus4;
            if_instr <= im_dout;
            if_pc    <= pc;
            if_pc4   <= pc_plus4;
            if_valid <= 1'b1;
            if (fetch_cnt != '1)
               fetch_cnt <= fetch_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: expected IF/ID contents are queued per step and
// popped after the clock edge for comparison.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush, br_taken, jump, jr;
   logic [31:0] br_target, jr_target;
   logic [25:0] jump_index;
   logic        im_rd;
   logic [9:0]  im_addr;
   logic [31:0] im_dout;
   logic [31:0] pc, if_pc, if_pc4, if_instr;
   logic        if_valid, pc_misalign;
   logic [31:0] fetch_cnt, stall_cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] ipc;
      logic        valid;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   // Memory model: each word holds its own byte address (word index * 4).
   assign im_dout = {20'd0, im_addr, 2'b00};

   pc_fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .flush       (flush),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .jump        (jump),
      .jump_index  (jump_index),
      .jr          (jr),
      .jr_target   (jr_target),
      .im_rd       (im_rd),
      .im_addr     (im_addr),
      .im_dout     (im_dout),
      .pc          (pc),
      .if_pc       (if_pc),
      .if_pc4      (if_pc4),
      .if_instr    (if_instr),
      .if_valid    (if_valid),
      .pc_misalign (pc_misalign),
      .fetch_cnt   (fetch_cnt),
      .stall_cnt   (stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic fl, input logic st,
                       input logic br, input logic [31:0] brt,
                       input logic jm, input logic [25:0] ji,
                       input logic j_r, input logic [31:0] jrt,
                       input logic [31:0] e_pc, input logic [31:0] e_instr,
                       input logic [31:0] e_ipc, input logic e_valid);
      exp_t e;
      flush = fl; stall = st;
      br_taken = br; br_target = brt;
      jump = jm; jump_index = ji;
      jr = j_r; jr_target = jrt;
      sb.push_back('{pc: e_pc, instr: e_instr, ipc: e_ipc, valid: e_valid});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("pc", pc, e.pc);
      chk("if_instr", if_instr, e.instr);
      chk("if_pc", if_pc, e.ipc);
      chk("if_valid", {31'd0, if_valid}, {31'd0, e.valid});
   endtask

   initial begin
      #20000;
      failures++;
      $display("FAIL watchdog timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      stall = 0; flush = 0; br_taken = 0; jump = 0; jr = 0;
      br_target = '0; jr_target = '0; jump_index = '0;
      #12;
      chk("rst_pc", pc, 32'h0);
      chk("rst_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_im_rd", {31'd0, im_rd}, 32'd0);
      chk("rst_fetch_cnt", fetch_cnt, 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_im_rd", {31'd0, im_rd}, 32'd1);
      chk("rel_im_addr", {22'd0, im_addr}, 32'd0);

      // Free-running fetch from reset
      step(0,0, 0,0, 0,0, 0,0, 32'h4,  32'h0, 32'h0, 1);
      step(0,0, 0,0, 0,0, 0,0, 32'h8,  32'h4, 32'h4, 1);
      chk("fetch_cnt_2", fetch_cnt, 32'd2);

      // Stall at pc=0x8 for three cycles
      step(0,1, 0,0, 0,0, 0,0, 32'h8,  32'h4, 32'h4, 1);
      step(0,1, 0,0, 0,0, 0,0, 32'h8,  32'h4, 32'h4, 1);
      step(0,1, 0,0, 0,0, 0,0, 32'h8,  32'h4, 32'h4, 1);
      chk("stall_cnt_3", stall_cnt, 32'd3);
      chk("fetch_cnt_frozen", fetch_cnt, 32'd2);

      step(0,0, 0,0, 0,0, 0,0, 32'hC,  32'h8, 32'h8, 1);
      step(0,0, 0,0, 0,0, 0,0, 32'h10, 32'hC, 32'hC, 1);

      // Taken branch at pc=0x10 -> bubble, then instruction from 0x40
      step(0,0, 1,32'h40, 0,0, 0,0, 32'h40, 32'h0, 32'hC, 0);
      chk("im_addr_40", {22'd0, im_addr}, 32'h10);
      step(0,0, 0,0, 0,0, 0,0, 32'h44, 32'h40, 32'h40, 1);

      // jr beats jump and branch in the same cycle
      step(0,0, 1,32'h200, 1,26'h3, 1,32'h80, 32'h80, 32'h0, 32'h40, 0);
      chk("no_misalign", {31'd0, pc_misalign}, 32'd0);
      // Misaligned jr target forced to word boundary, flag sticks
      step(0,0, 0,0, 0,0, 1,32'h82, 32'h80, 32'h0, 32'h40, 0);
      chk("misalign_set", {31'd0, pc_misalign}, 32'd1);
      step(0,0, 0,0, 0,0, 0,0, 32'h84, 32'h80, 32'h80, 1);
      chk("misalign_sticky", {31'd0, pc_misalign}, 32'd1);

      // Jump uses the upper nibble of if_pc4
      step(0,0, 0,0, 0,0, 1,32'h1000_0000, 32'h1000_0000, 32'h0, 32'h80, 0);
      step(0,0, 0,0, 0,0, 0,0, 32'h1000_0004, 32'h0, 32'h1000_0000, 1);
      chk("if_pc4", if_pc4, 32'h1000_0004);
      step(0,0, 0,0, 1,26'h0000100, 0,0, 32'h1000_0400, 32'h0, 32'h1000_0000, 0);
      chk("im_addr_jump", {22'd0, im_addr}, 32'h100);

      // Flush wins over stall: sequential advance, bubble inserted
      step(1,1, 0,0, 0,0, 0,0, 32'h1000_0404, 32'h0, 32'h1000_0000, 0);
      chk("fetch_cnt_7", fetch_cnt, 32'd7);

      // Sequential wrap at the top of the address space
      step(0,0, 0,0, 0,0, 1,32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h1000_0000, 0);
      step(0,0, 0,0, 0,0, 0,0, 32'h0, 32'hFFC, 32'hFFFF_FFFC, 1);
      chk("if_pc4_wrap", if_pc4, 32'h0);
      chk("fetch_cnt_8", fetch_cnt, 32'd8);

      // Asynchronous reset in the middle of a stall
      stall = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_pc", pc, 32'h0);
      chk("async_instr", if_instr, 32'h0);
      chk("async_valid", {31'd0, if_valid}, 32'd0);
      chk("async_misalign", {31'd0, pc_misalign}, 32'd0);
      chk("async_fetch_cnt", fetch_cnt, 32'd0);
      chk("async_stall_cnt", stall_cnt, 32'd0);
      chk("async_if_pc", if_pc, 32'h0);
      chk("async_im_rd", {31'd0, im_rd}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
